// File: rtl/muldiv_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: operation codes,
// FSM states and default latencies.
package muldiv_pkg;

    typedef enum logic [2:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MTHI  = 3'd4,
        MD_MTLO  = 3'd5,
        MD_NOP6  = 3'd6,
        MD_NOP7  = 3'd7
    } md_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } md_state_e;

    localparam int DEFAULT_MULT_CYCLES = 5;
    localparam int DEFAULT_DIV_CYCLES  = 10;
    localparam int CNT_W               = 5;

    // Ops 0..3 are the multi-cycle arithmetic operations (bit 2 clear).
    function automatic logic is_arith(input logic [2:0] op);
        return (op[2] == 1'b0);
    endfunction

endpackage

// File: rtl/muldiv_arith.sv
// Purely combinational datapath: produces the 64-bit {hi,lo} result for the
// latched operation, including divide-by-zero and signed-overflow handling.
module muldiv_arith
    import muldiv_pkg::*;
(
    input  md_op_e      op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [63:0] result
);

    logic signed [63:0] prod_s;
    logic        [63:0] prod_u;
    logic signed [31:0] quo_s;
    logic signed [31:0] rem_s;
    logic        [31:0] quo_u;
    logic        [31:0] rem_u;
    logic               div_zero;
    logic               div_ovf;

    assign prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    assign prod_u = {32'b0, a} * {32'b0, b};

    // Quotients/remainders are only evaluated when the divisor is legal, so
    // the simulator never sees a zero divisor or the overflowing pair.
    always_comb begin
        div_zero = (b == 32'h0);
        div_ovf  = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        quo_s    = '0;
        rem_s    = '0;
        quo_u    = '0;
        rem_u    = '0;
        if (!div_zero && !div_ovf) begin
            quo_s = $signed(a) / $signed(b);
            rem_s = $signed(a) % $signed(b);
        end
        if (!div_zero) begin
            quo_u = a / b;
            rem_u = a % b;
        end
    end

    // Select the result for the operation; remainder goes to hi, quotient to lo.
    always_comb begin
        result = '0;
        case (op)
            MD_MULT:  result = prod_s;
            MD_MULTU: result = prod_u;
            MD_DIV: begin
                if (div_zero)
                    result = {a, 32'hFFFF_FFFF};
                else if (div_ovf)
                    result = {32'h0, 32'h8000_0000};
                else
                    result = {rem_s, quo_s};
            end
            MD_DIVU: begin
                if (div_zero)
                    result = {a, 32'hFFFF_FFFF};
                else
                    result = {rem_u, quo_u};
            end
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/muldiv_unit.sv
// E-stage multi-cycle multiply/divide unit owning HI/LO. Latches operands on
// Start, holds Busy for a fixed latency, then commits HI/LO and pulses Done.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int MULT_CYCLES = DEFAULT_MULT_CYCLES,
    parameter int DIV_CYCLES  = DEFAULT_DIV_CYCLES
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Start,
    input  logic [2:0]  Op,
    input  logic [31:0] D1,
    input  logic [31:0] D2,
    input  logic        Flush,
    output logic        Busy,
    output logic        Stall_Req,
    output logic        Done,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

    md_state_e        state;
    logic [CNT_W-1:0] cnt;
    md_op_e           op_q;
    logic [31:0]      a_q;
    logic [31:0]      b_q;
    logic [63:0]      result;

    muldiv_arith u_arith (
        .op     (op_q),
        .a      (a_q),
        .b      (b_q),
        .result (result)
    );

    assign Busy      = (state == ST_BUSY);
    assign Stall_Req = Busy | (Start & is_arith(Op) & ~Flush);

    // Operation FSM: accept in IDLE, count down in BUSY, commit or abort.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state <= ST_IDLE;
            cnt   <= '0;
            op_q  <= MD_MULT;
            a_q   <= '0;
            b_q   <= '0;
            HI    <= '0;
            LO    <= '0;
            Done  <= 1'b0;
        end else begin
            Done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (Start && !Flush) begin
                        case (md_op_e'(Op))
                            MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: begin
                                a_q   <= D1;
                                b_q   <= D2;
                                op_q  <= md_op_e'(Op);
                                cnt   <= Op[1] ? DIV_LOAD : MULT_LOAD;
                                state <= ST_BUSY;
                            end
                            MD_MTHI: HI <= D1;
                            MD_MTLO: LO <= D1;
                            default: ;
                        endcase
                    end
                end
                ST_BUSY: begin
                    if (Flush) begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                    end else if (cnt == '0) begin
                        HI    <= result[63:32];
                        LO    <= result[31:0];
                        Done  <= 1'b1;
                        state <= ST_IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed corner cases plus random
// arithmetic ops, all compared against a plain-arithmetic reference model.
module tb_muldiv_unit;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  op    = 3'd0;
    logic [31:0] d1    = '0;
    logic [31:0] d2    = '0;
    logic        flush = 1'b0;
    logic        busy;
    logic        stall_req;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_hi = '0;
    logic [31:0] exp_lo = '0;

    muldiv_unit #(
        .MULT_CYCLES (MULT_N),
        .DIV_CYCLES  (DIV_N)
    ) dut (
        .Clk       (clk),
        .Reset     (rst_n),
        .Start     (start),
        .Op        (op),
        .D1        (d1),
        .D2        (d2),
        .Flush     (flush),
        .Busy      (busy),
        .Stall_Req (stall_req),
        .Done      (done),
        .HI        (hi),
        .LO        (lo)
    );

    // Free-running 100 MHz clock.
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv)
        else begin
            errors++;
            $error("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, obs, expv);
        end
    endtask

    // Reference: MIPS HI/LO results from wide integer arithmetic.
    function automatic logic [63:0] model(input logic [2:0] mop, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        longint unsigned ua, ub;
        sa = $signed(a);
        sb = $signed(b);
        ua = {32'b0, a};
        ub = {32'b0, b};
        case (mop)
            3'd0: return sa * sb;
            3'd1: return ua * ub;
            3'd2: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            default: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
        endcase
    endfunction

    // Issue one arithmetic op; optionally inject a stray divu Start mid-flight.
    task automatic run_op(input string tag, input logic [2:0] mop, input logic [31:0] a,
                          input logic [31:0] b, input int intrude_at);
        logic [63:0] res;
        int          n;
        int          cycles;
        res = model(mop, a, b);
        n   = mop[1] ? DIV_N : MULT_N;
        @(negedge clk);
        start = 1'b1; op = mop; d1 = a; d2 = b;
        #1;
        check({tag, " stall_req"}, stall_req, 1);
        @(posedge clk); #1;
        start = 1'b0;
        d1 = $urandom;
        d2 = $urandom;
        cycles = 0;
        while (busy === 1'b1 && cycles < 40) begin
            cycles++;
            if (cycles == intrude_at) begin
                start = 1'b1; op = 3'd3;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        check({tag, " busy_cycles"}, cycles, n);
        check({tag, " done"}, done, 1);
        check({tag, " hi"}, hi, res[63:32]);
        check({tag, " lo"}, lo, res[31:0]);
        exp_hi = res[63:32];
        exp_lo = res[31:0];
        @(posedge clk); #1;
        check({tag, " done_pulse"}, done, 0);
    endtask

    // Single-cycle idle-state request (mthi/mtlo/no-op, or any op under flush).
    task automatic idle_step(input string tag, input logic [2:0] mop, input logic [31:0] v, input logic fl);
        @(negedge clk);
        start = 1'b1; op = mop; d1 = v; d2 = $urandom; flush = fl;
        #1;
        check({tag, " stall_req"}, stall_req, 0);
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        if (!fl && mop == 3'd4) exp_hi = v;
        if (!fl && mop == 3'd5) exp_lo = v;
        check({tag, " busy"}, busy, 0);
        check({tag, " hi"}, hi, exp_hi);
        check({tag, " lo"}, lo, exp_lo);
        @(posedge clk); #1;
        check({tag, " done"}, done, 0);
    endtask

    // Start mult 3*4 and flush it after the given number of busy edges.
    task automatic abort_op(input string tag, input int edges_before);
        @(negedge clk);
        start = 1'b1; op = 3'd0; d1 = 32'd3; d2 = 32'd4;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (edges_before) @(posedge clk);
        #1;
        check({tag, " busy_before"}, busy, 1);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check({tag, " busy_after"}, busy, 0);
        check({tag, " done"}, done, 0);
        check({tag, " hi"}, hi, exp_hi);
        check({tag, " lo"}, lo, exp_lo);
        @(posedge clk); #1;
        check({tag, " done_late"}, done, 0);
    endtask

    // Directed sequence followed by randomized operations.
    initial begin
        logic [2:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;

        #2 rst_n = 1'b0;
        #10;
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset hi", hi, 0);
        check("reset lo", lo, 0);
        check("reset stall_req", stall_req, 0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("mult_neg", 3'd0, 32'hFFFF_FFFD, 32'd5, 0);
        check("mult_neg hi const", exp_hi, 32'hFFFF_FFFF);
        check("mult_neg lo const", lo, 32'hFFFF_FFF1);
        run_op("divu_100_7", 3'd3, 32'd100, 32'd7, 0);
        check("divu lo const", lo, 32'd14);
        check("divu hi const", hi, 32'd2);
        run_op("div_neg", 3'd2, 32'hFFFF_FFF9, 32'd2, 0);
        check("div_neg lo const", lo, 32'hFFFF_FFFD);
        check("div_neg hi const", hi, 32'hFFFF_FFFF);
        run_op("div_zero", 3'd2, 32'h1234_5678, 32'd0, 0);
        check("div_zero lo const", lo, 32'hFFFF_FFFF);
        run_op("divu_zero", 3'd3, 32'hDEAD_BEEF, 32'd0, 0);
        run_op("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        check("div_ovf lo const", lo, 32'h8000_0000);
        check("div_ovf hi const", hi, 32'h0);
        run_op("multu_big", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);

        idle_step("mthi", 3'd4, 32'hAAAA_0000, 1'b0);
        idle_step("mtlo", 3'd5, 32'h0000_5555, 1'b0);
        idle_step("nop6", 3'd6, 32'h1111_1111, 1'b0);
        idle_step("nop7", 3'd7, 32'h2222_2222, 1'b0);
        idle_step("flush_mthi", 3'd4, 32'h3333_3333, 1'b1);
        idle_step("flush_mult", 3'd0, 32'h4444_4444, 1'b1);

        abort_op("flush_mid", 2);
        abort_op("flush_commit", MULT_N - 1);

        run_op("start_in_busy", 3'd0, 32'd7, 32'd9, 2);

        @(negedge clk);
        start = 1'b1; op = 3'd3; d1 = 32'd1000; d2 = 32'd3;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        exp_hi = '0;
        exp_lo = '0;
        check("async_reset busy", busy, 0);
        check("async_reset hi", hi, 0);
        check("async_reset lo", lo, 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op("post_reset_mult", 3'd0, 32'd2, 32'd3, 0);
        check("post_reset lo const", lo, 32'd6);

        for (int i = 0; i < 12; i++) begin
            rop = 3'($urandom_range(0, 3));
            ra  = $urandom;
            case ($urandom_range(0, 5))
                0:       rb = 32'd0;
                1:       rb = 32'($urandom_range(1, 9));
                2:       rb = 32'hFFFF_FFFF;
                default: rb = $urandom;
            endcase
            run_op($sformatf("rand%0d", i), rop, ra, rb, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Multi-cycle multiply/divide unit in the E stage of the 5-stage MIPS pipeline; owns the HI/LO registers.
- Responds to the hazard unit's stall protocol: it raises Stall_Req while an operation is pending, and the hazard unit stalls any HI/LO-dependent instruction in D.
- Executes mult, multu, div, divu, mthi and mtlo. The ctrl decoder supplies Start and Op.

Parameters:
- MULT_CYCLES, 5, cycles Busy is held for mult/multu (≥1).
- DIV_CYCLES, 10, cycles Busy is held for div/divu (≥1).

Ports:
- Clk  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-low reset.
- Start  in  1  E-stage instruction is a muldiv op; qualified by Op.
- Op  in  3  0=mult 1=multu 2=div 3=divu 4=mthi 5=mtlo; 6,7 = no-op.
- D1  in  32  forwarded rs value.
- D2  in  32  forwarded rt value.
- Flush  in  1  exception/eret cancel from CP0.
- Busy  out  1  operation in progress.
- Stall_Req  out  1  to hazard unit; combinational Busy | (Start & Op<=3 & !Flush).
- Done  out  1  one-cycle pulse after HI/LO commit.
- HI  out  32  HI register.
- LO  out  32  LO register.

Behaviour:
- Reset (Reset=0, asynchronous): state=IDLE, cnt=0, Busy=0, Done=0, HI=0, LO=0. An in-flight operation is discarded.
- States: IDLE, BUSY. Internal registers: cnt[4:0], operand latches A/B, latched op.
- IDLE with Start & !Flush & Op in 0..3, at edge k:
  - latch D1/D2/Op;
  - cnt <= N-1 (N = MULT_CYCLES or DIV_CYCLES);
  - state <= BUSY.
- BUSY, each edge:
  - if cnt==0: commit HI/LO, state <= IDLE, Done <= 1;
  - else: cnt <= cnt-1.
- Timing: Busy=1 for exactly N cycles after edge k. HI/LO take the new value at edge k+N. Done=1 during the cycle after k+N. Back-to-back Start is accepted at edge k+N.
- mthi/mtlo in IDLE (Start & !Flush): HI<=D1 or LO<=D1 at the next edge. No Busy, no Done, Stall_Req=0.
- Start while BUSY: ignored, no state change. The hazard unit guarantees this never happens; the bench asserts it.
- Flush:
  - In IDLE, suppresses Start and mthi/mtlo.
  - In BUSY, aborts: state <= IDLE, HI/LO keep their pre-operation values, no Done.
  - Flush coincident with the commit edge (cnt==0): the flush wins, no commit.
- mult: {HI,LO} = signed(A)*signed(B), 64-bit. multu: unsigned.
- div: LO = quotient truncated toward zero; HI = remainder with the sign of the dividend.
  - Overflow 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- divu: unsigned quotient in LO, remainder in HI.
- Divide by zero (both signednesses): LO=0xFFFFFFFF, HI=A.
- Op 6/7 with Start: no effect, Stall_Req=0.
- Results are computed from the latched operands only. Changes on D1/D2 during BUSY have no effect.

Decomposition:
- Add header_muldiv.v (included like the other header_*.v files). It holds:
  - `md_mult .. `md_mtlo op codes;
  - default cycle counts.
- ctrl gains an Op output using these constants. The hazard unit gains a new class `hzd_md (mf*/mult/div in D) that stalls on Stall_Req.
- One sub-module, muldiv_arith: purely combinational. Takes op, A, B; produces the 64-bit {hi,lo} result including the div-by-zero and overflow rules. The FSM and registers stay in muldiv_unit.

Test Plan:
- mult D1=0xFFFFFFFD (-3), D2=5 -> Busy high 5 cycles; at edge k+5 HI=0xFFFFFFFF, LO=0xFFFFFFF1; Done pulses once.
- divu D1=100, D2=7 -> Busy 10 cycles; LO=14, HI=2. Then div D1=0xFFFFFFF9 (-7), D2=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- div D1=0x12345678, D2=0 -> LO=0xFFFFFFFF, HI=0x12345678. div 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
- Preload HI=0xAAAA0000 via mthi, LO=0x5555 via mtlo; mult 3*4; Flush at cycle 3 of BUSY -> Busy drops the next cycle, HI=0xAAAA0000, LO=0x5555, no Done. Repeat with Flush exactly on the commit edge -> same result.
- Start mult, then pulse Start again with Op=divu during BUSY -> ignored; HI/LO reflect the mult only; Busy length unchanged.
- Reset asserted asynchronously mid-divide (between clock edges) -> Busy/HI/LO go to 0 immediately. After release, a new mult 2*3 completes normally with LO=6.
